// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor with signed overflow; define KS_ADDER_SAT_EN for signed saturation.
// Latency: D = 1 + ceil(LVL/REG_EVERY) cycles from accept to out_valid; one op per cycle when not stalled.
// Backpressure: global stall, all stages hold while out_valid & !out_ready; in_ready mirrors that advance.
module ks_adder_pipe #(
   parameter int N         = 64,
   parameter int REG_EVERY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   localparam int LVL = $clog2(N);
   localparam int S   = (LVL + REG_EVERY - 1) / REG_EVERY;

   logic         init_done;
   logic         advance;

   logic         vq  [S];
   logic [N-1:0] gq  [S];
   logic [N-1:0] pq  [S];
   logic [N-1:0] hpq [S];
   logic         c0q [S];
   logic [N-1:0] gn  [S];
   logic [N-1:0] pn  [S];

   logic [N-1:0] bx, g0, p0;
   logic         c0;
   logic [N-1:0] gt, pt, lowm;
   logic [N-1:0] cv, sum_n;
   logic         cout_n, ovf_n;

   assign advance  = !out_valid | out_ready;
   assign in_ready = init_done & advance;

   always_comb begin
      bx    = sub ? ~b : b;
      c0    = sub | cin;
      g0    = a & bx;
      p0    = a ^ bx;
      // c0 acts as the bit -1 generate; absorbing it into bit 0 keeps the tree N bits wide.
      g0[0] = g0[0] | (p0[0] & c0);
   end

   always_comb begin
      gt   = '0;
      pt   = '0;
      lowm = '0;
      for (int s = 0; s < S; s++) begin
         gt = gq[s];
         pt = pq[s];
         for (int j = 0; j < REG_EVERY; j++) begin
            if (s * REG_EVERY + j < LVL) begin
               lowm = (N'(1) << (1 << (s * REG_EVERY + j))) - N'(1);
               gt   = gt | (pt & (gt << (1 << (s * REG_EVERY + j))));
               pt   = pt & ((pt << (1 << (s * REG_EVERY + j))) | lowm);
            end
         end
         gn[s] = gt;
         pn[s] = pt;
      end
   end

   always_comb begin
      cv     = {gn[S-1][N-2:0], c0q[S-1]};
      sum_n  = hpq[S-1] ^ cv;
      cout_n = gn[S-1][N-1];
      ovf_n  = gn[S-1][N-2] ^ gn[S-1][N-1];
`ifdef KS_ADDER_SAT_EN
      // Carry into the MSB set means both operands were non-negative: clamp to max positive.
      if (ovf_n) begin
         sum_n = gn[S-1][N-2] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_done <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         for (int s = 0; s < S; s++) begin
            vq[s]  <= 1'b0;
            gq[s]  <= '0;
            pq[s]  <= '0;
            hpq[s] <= '0;
            c0q[s] <= 1'b0;
         end
      end else begin
         init_done <= 1'b1;
         if (advance) begin
            vq[0]  <= in_valid & in_ready;
            gq[0]  <= g0;
            pq[0]  <= p0;
            hpq[0] <= p0;
            c0q[0] <= c0;
            for (int s = 1; s < S; s++) begin
               vq[s]  <= vq[s-1];
               gq[s]  <= gn[s-1];
               pq[s]  <= pn[s-1];
               hpq[s] <= hpq[s-1];
               c0q[s] <= c0q[s-1];
            end
            out_valid <= vq[S-1];
            sum       <= sum_n;
            cout      <= cout_n;
            ovf       <= ovf_n;
         end
      end
   end
endmodule
